mr_wb_arb: RTL
==============

# mr_wb_arb

Two-master, one-slave pipelined Wishbone arbiter directly downstream of the core's two bus masters: instruction fetch (m0) and load/store (m1). It merges them onto the single system bus (s). It holds a grant for the whole of a master's CYC, round-robins between masters under contention, and tracks outstanding transfers so ACK/ERR are routed only to the owning master.

## Interface
Parameters:
- `AW`, default `` `XLEN-`XLEN_GRAN ``: word-address width.
- `DW`, default `` `XLEN ``: data width; SEL width is `DW/8`.
- `MAX_OUT`, default 4: maximum accepted-but-unacknowledged transfers; must be ≥1.

Ports (`mN_*` is repeated for N = 0 and 1):
- Clock and reset (already decided): one clock, `clk`; reset `rst` is asynchronous and active-low (asserted when `rst` = 0).
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-low reset.
- `mN_adr_i`  in  AW  master address.
- `mN_dat_i`  in  DW  master write data.
- `mN_dat_o`  out  DW  read data to master.
- `mN_we_i`  in  1  write enable.
- `mN_sel_i`  in  DW/8  byte select.
- `mN_stb_i`  in  1  strobe.
- `mN_cyc_i`  in  1  cycle request.
- `mN_ack_o`  out  1  acknowledge.
- `mN_err_o`  out  1  error.
- `mN_stall_o`  out  1  stall.
- `s_adr_o`  out  AW  slave address.
- `s_dat_o`  out  DW  slave write data.
- `s_dat_i`  in  DW  slave read data.
- `s_we_o`  out  1  write enable.
- `s_sel_o`  out  DW/8  byte select.
- `s_stb_o`  out  1  strobe.
- `s_cyc_o`  out  1  cycle.
- `s_ack_i`  in  1  acknowledge.
- `s_err_i`  in  1  error.
- `s_stall_i`  in  1  stall.

## Operation
State register: IDLE, GNT0, GNT1. Also kept:
- `last` (1 bit): last master granted.
- `outst` (`$clog2(MAX_OUT+1)` bits): accepted transfers not yet answered.

Transitions:
- IDLE, only m0_cyc_i=1 -> GNT0.
- IDLE, only m1_cyc_i=1 -> GNT1.
- IDLE, both requesting -> grant the master ≠ `last`.
- GNTn with mn_cyc_i=0 -> re-arbitrate this cycle exactly as from IDLE; with no request, go to IDLE. `outst` is cleared to 0 (CYC drop aborts the cycle).
- GNTn with mn_cyc_i=1 -> stay; no preemption.
- Entering GNTn sets `last`=n.

Muxing (combinational from the state register):
- In GNTn: s_adr/dat/we/sel = master n's inputs; s_cyc_o = mn_cyc_i; s_stb_o = mn_stb_i & ~full.
- mn_stall_o = s_stall_i | full.
- mn_ack_o = s_ack_i; mn_err_o = s_err_i.
- mn_dat_o = s_dat_i, both masters always (data is qualified by ACK).
- Non-granted master: stall_o=1, ack_o=0, err_o=0.
- IDLE: s_cyc_o=0, s_stb_o=0, s_adr/dat/sel/we=0, both stall_o=1.

Counter:
- `full` = (outst == MAX_OUT).
- accept = s_stb_o & ~s_stall_i; resp = s_ack_i | s_err_i.
- outst += accept − resp. A simultaneous accept and resp leaves it unchanged.
- resp with outst=0 (protocol violation) is forwarded to the granted master; the counter saturates at 0.

## Timing
- Reset (rst=0, async): state=IDLE, last=1 (so m0 wins the first tie), outst=0. Outputs: s_cyc_o=0, s_stb_o=0, s_adr_o/s_dat_o/s_sel_o/s_we_o=0, mN_stall_o=1, mN_ack_o=0, mN_err_o=0.
- Reset deassertion is synchronised externally. Reset mid-transfer drops s_cyc_o immediately.
- Arbitration latency: a request first seen in IDLE is stalled for exactly one cycle. The request reaches the slave on the next cycle.
- Handover: the cycle after mn_cyc_i falls, the other master can already be driving s_*, giving one dead cycle.
- While granted: zero added latency. Slave stall, ACK and ERR pass through combinationally.
- Pipelining: up to MAX_OUT strobes may be accepted before the first ACK. The (MAX_OUT+1)th strobe sees stall=1 until a response arrives. When outst=MAX_OUT, a response in cycle t allows a strobe to be accepted in cycle t+1.

## Structure
- Add `e_arbstate` (IDLE/GNT0/GNT1) to the shared types package next to `e_memops`/`e_memsz`.
- `AW`/`DW` default from `` `XLEN ``/`` `XLEN_GRAN `` in `config.svi`.
- One sub-module, `mr_wb_arb_cnt`: the saturating outstanding counter with inc/dec/clr inputs and a `full` output.
- Muxing and the FSM stay in the top.

## Test plan
- Reset with m0 and m1 requesting: after release, cycle 1 both stall=1; cycle 2 s_adr_o=m0_adr_i=0x100, m1_stall_o=1.
- m1 alone, single read: the slave ACKs with s_dat_i=0xDEADBEEF one cycle after accept. Expect m1_ack_o=1, m1_dat_o=0xDEADBEEF, m0_ack_o=0, outst returns to 0.
- Contention: m0 and m1 hold CYC continuously, each for one transfer then drop. Grants alternate m0, m1, m0, with exactly one dead cycle between them.
- MAX_OUT=4, m0 issues 6 strobes, slave never stalls and ACKs starting cycle 6: strobes 1–4 are accepted, strobe 5 sees stall=1 until the first ACK, and all 6 ACKs go to m0.
- m1 drops CYC with outst=2: s_cyc_o falls the same cycle, outst=0, and a later stray s_ack_i in IDLE reaches neither master.
- s_err_i during a GNT1 write with sel=4'b0011: m1_err_o=1, m0_err_o=0, and outst decrements.

Source files
------------

// File: rtl/mr_wb_arb_pkg.sv
// Shared bus types for the core's memory side, including the arbiter state
// and the round-robin pick helper used by mr_wb_arb.
package mr_wb_arb_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned XLEN_GRAN = 2;

  typedef enum logic [1:0] {MemOpNone, MemOpLoad, MemOpStore} e_memops;
  typedef enum logic [1:0] {MemSzByte, MemSzHalf, MemSzWord} e_memsz;
  typedef enum logic [1:0] {ArbIdle, ArbGnt0, ArbGnt1} e_arbstate;

  // On a tie the master that was not granted last wins.
  function automatic e_arbstate arb_pick(input logic req0, input logic req1, input logic last);
    if (req0 && req1) begin
      return last ? ArbGnt0 : ArbGnt1;
    end else if (req0) begin
      return ArbGnt0;
    end else if (req1) begin
      return ArbGnt1;
    end
    return ArbIdle;
  endfunction

endpackage

// File: rtl/mr_wb_arb_cnt.sv
// Outstanding-transfer counter: counts accepted strobes not yet answered,
// saturates at zero on stray responses, and flags when the pipeline is full.
module mr_wb_arb_cnt #(
  parameter int unsigned MAX_OUT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_dec,
  input  logic i_clr,
  output logic o_full
);

  localparam int unsigned CW = $clog2(MAX_OUT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec) begin
      r_cnt <= r_cnt + CW'(1);
    end else if (i_dec && !i_inc && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_full = (r_cnt == CW'(MAX_OUT));

endmodule

// File: rtl/mr_wb_arb.sv
// Two-master pipelined Wishbone arbiter: holds a grant for a whole CYC,
// round-robins on contention and limits accepted-but-unanswered strobes.
module mr_wb_arb
  import mr_wb_arb_pkg::*;
#(
  parameter int unsigned AW      = XLEN - XLEN_GRAN,
  parameter int unsigned DW      = XLEN,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_stb_i,
  input  logic            m0_cyc_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic            m0_stall_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_stb_i,
  input  logic            m1_cyc_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            m1_stall_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic [DW-1:0]   s_dat_i,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_stb_o,
  output logic            s_cyc_o,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  input  logic            s_stall_i
);

  e_arbstate r_state;
  e_arbstate w_next;
  logic      r_last;
  logic      w_cur_cyc;
  logic      w_drop;
  logic      w_full;
  logic      w_accept;
  logic      w_resp;

  always_comb begin
    unique case (r_state)
      ArbGnt0: w_cur_cyc = m0_cyc_i;
      ArbGnt1: w_cur_cyc = m1_cyc_i;
      default: w_cur_cyc = 1'b0;
    endcase
  end

  // Dropping CYC aborts the cycle and frees the bus for re-arbitration.
  assign w_drop = (r_state != ArbIdle) && !w_cur_cyc;

  always_comb begin
    w_next = r_state;
    if (r_state == ArbIdle || w_drop) begin
      w_next = arb_pick(m0_cyc_i, m1_cyc_i, r_last);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ArbIdle;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_next == ArbGnt0) begin
        r_last <= 1'b0;
      end else if (w_next == ArbGnt1) begin
        r_last <= 1'b1;
      end
    end
  end

  always_comb begin
    s_adr_o    = '0;
    s_dat_o    = '0;
    s_we_o     = 1'b0;
    s_sel_o    = '0;
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    m0_stall_o = 1'b1;
    m1_stall_o = 1'b1;
    m0_ack_o   = 1'b0;
    m1_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m1_err_o   = 1'b0;
    unique case (r_state)
      ArbGnt0: begin
        s_adr_o    = m0_adr_i;
        s_dat_o    = m0_dat_i;
        s_we_o     = m0_we_i;
        s_sel_o    = m0_sel_i;
        s_cyc_o    = m0_cyc_i;
        s_stb_o    = m0_stb_i && !w_full;
        m0_stall_o = s_stall_i || w_full;
        m0_ack_o   = s_ack_i;
        m0_err_o   = s_err_i;
      end
      ArbGnt1: begin
        s_adr_o    = m1_adr_i;
        s_dat_o    = m1_dat_i;
        s_we_o     = m1_we_i;
        s_sel_o    = m1_sel_i;
        s_cyc_o    = m1_cyc_i;
        s_stb_o    = m1_stb_i && !w_full;
        m1_stall_o = s_stall_i || w_full;
        m1_ack_o   = s_ack_i;
        m1_err_o   = s_err_i;
      end
      default: begin
      end
    endcase
  end

  // Read data is qualified by ACK, so both masters see it unconditionally.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  assign w_accept = s_stb_o && !s_stall_i;
  assign w_resp   = s_ack_i || s_err_i;

  mr_wb_arb_cnt #(
    .MAX_OUT (MAX_OUT)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_inc  (w_accept),
    .i_dec  (w_resp),
    .i_clr  (w_drop),
    .o_full (w_full)
  );

endmodule
